ping_scheduler: RTL and testbench
=================================

Name: ping_scheduler

Overview:
- Sequences one ultrasonic ranging channel.
- Issues the transducer trigger pulse, times the echo pulse, and converts echo width into a 16-bit distance.
- Applies the parking threshold with hit/miss debounce and drives the debounced alarm to the buzzer/indicator logic.
- Sits between the sensor pads (trigger out, echo in) and the alarm output stage; runs measurements back-to-back while enabled.

Parameters:
TRIG_CYCLES, 10, trigger pulse width in clk cycles (>=1)
ECHO_TIMEOUT, 30000, max cycles waiting for the echo rise, and max echo-high width, before declaring no-object (<=65535)
HOLDOFF_CYCLES, 60000, dead time after each measurement before the next trigger (>=1)
DIST_SHIFT, 6, distance_value = echo_cycles >> DIST_SHIFT
THRESHOLD, 200, a measurement is a hit when 0 < distance < THRESHOLD
HIT_COUNT, 3, consecutive hits to raise the alarm, or consecutive misses to clear it (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  run measurements while high
echo_in  input  1  raw echo from sensor, asynchronous to clk
trig_out  output  1  trigger pulse to transducer
busy  output  1  high in any state other than IDLE
distance_value  output  16  last measured distance, 0 = invalid/no object
distance_valid  output  1  one-cycle strobe when distance_value updates
timeout  output  1  one-cycle strobe, coincident with distance_valid, when the measurement timed out
alarm_active  output  1  debounced proximity alarm

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, all counters 0, sync flops 0. Reset mid-measurement aborts immediately: trig_out drops asynchronously and no strobe is issued.
- Echo synchronisation: echo_in passes through a 2-flop synchronizer, giving 2 cycles of latency. Edges are detected on the synced signal vs its previous value.
- IDLE: if enable=1, go to TRIG next cycle.
- TRIG: trig_out=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE. The cycle counter clears on entry.
- WAIT_RISE:
  - Counter increments each cycle.
  - A synced rising edge moves to MEASURE with the echo counter cleared.
  - An echo already high on entry does not count; a low-to-high transition is required.
  - If the counter reaches ECHO_TIMEOUT first: timeout result, go to HOLDOFF.
- MEASURE:
  - Echo counter increments each cycle the synced echo is high.
  - On the synced falling edge: distance_value = count >> DIST_SHIFT (16-bit, zero-extended), distance_valid=1 for that one cycle, then HOLDOFF.
  - If the count reaches ECHO_TIMEOUT before the fall: timeout result, go to HOLDOFF.
- Timeout result: distance_value=0, distance_valid=1 and timeout=1 for one cycle.
- HOLDOFF: wait HOLDOFF_CYCLES cycles, ignoring echo, then go to IDLE.
- Measurement rate: IDLE re-triggers on the next cycle if enable is still high, so the period is TRIG + echo + HOLDOFF + 1.
- enable deasserted mid-measurement: the current measurement completes normally (strobe issued), then the block parks in IDLE. enable does not affect alarm_active.
- Debounce, evaluated on each distance_valid cycle:
  - hit = (distance_value != 0) && (distance_value < THRESHOLD). Distance equal to THRESHOLD is a miss; 0 (timeout) is a miss.
  - A hit increments hit_cnt and clears miss_cnt; a miss does the converse. Both counters saturate at HIT_COUNT.
  - alarm_active sets on the cycle after hit_cnt reaches HIT_COUNT, and clears on the cycle after miss_cnt reaches HIT_COUNT.
- Arithmetic: the echo counter is 16-bit and cannot wrap, since ECHO_TIMEOUT <= 65535 bounds it. The shift truncates.
- Simultaneous events: a falling edge in the same cycle the count reaches ECHO_TIMEOUT counts as a timeout.

Test Plan:
Common parameters for all scenarios: TRIG_CYCLES=4, ECHO_TIMEOUT=4000, HOLDOFF_CYCLES=20, DIST_SHIFT=2, THRESHOLD=200, HIT_COUNT=2.
1. Assert enable; echo rises 50 cycles after trig falls and stays high 600 cycles -> trig_out high exactly 4 cycles; distance_value=150, distance_valid one cycle, timeout=0; next trig_out rises 21 cycles after the strobe.
2. Three consecutive echoes of 2000 cycles (distance 500) -> distance_value=500 each time, alarm_active stays 0.
3. Echo width 800 (distance 200) twice, then 600 (150) twice -> no alarm after the 200s; alarm_active=1 on the cycle after the second 150 strobe.
4. With alarm set, never raise echo -> each measurement times out after 4000 WAIT_RISE cycles with distance_value=0, timeout=1; alarm_active clears after the second timeout.
5. Hold echo_in high through TRIG and WAIT_RISE -> no MEASURE entry, timeout result; then echo width 40 (distance 10) twice -> alarm_active=1.
6. Pulse rst mid-MEASURE; separately drop enable mid-MEASURE -> reset: all outputs 0 at once, no strobe. Enable drop: measurement completes with one strobe, busy falls after HOLDOFF, no further trig_out.

Source files
------------

// File: rtl/ping_scheduler.sv
// rtl/ping_scheduler.sv - ultrasonic ranging sequencer with threshold debounce and alarm output
module ping_scheduler #(
  parameter int TRIG_CYCLES    = 10,
  parameter int ECHO_TIMEOUT   = 30000,
  parameter int HOLDOFF_CYCLES = 60000,
  parameter int DIST_SHIFT     = 6,
  parameter int THRESHOLD      = 200,
  parameter int HIT_COUNT      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo_in,
  output logic        trig_out,
  output logic        busy,
  output logic [15:0] distance_value,
  output logic        distance_valid,
  output logic        timeout,
  output logic        alarm_active
);

  localparam int HW = $clog2(HIT_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cyc_cnt_q, cyc_cnt_d;
  logic [15:0]     echo_cnt_q, echo_cnt_d;
  logic [15:0]     dist_q, dist_d;
  logic            valid_q, valid_d;
  logic            tmo_q, tmo_d;
  logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [HW-1:0]   miss_cnt_q, miss_cnt_d;
  logic            alarm_q, alarm_d;
  logic            echo_s1_q, echo_s2_q, echo_prev_q;
  logic            echo_rise, echo_fall, is_hit;

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;
  assign is_hit    = (dist_q != 16'd0) && (dist_q < 16'(THRESHOLD));

  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    echo_cnt_d = echo_cnt_q;
    dist_d     = dist_q;
    valid_d    = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = TRIG;
          cyc_cnt_d = 32'd0;
        end
      end
      TRIG: begin
        if (cyc_cnt_q == 32'(TRIG_CYCLES - 1)) begin
          state_d   = WAIT_RISE;
          cyc_cnt_d = 32'd0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d    = MEASURE;
          echo_cnt_d = 16'd0;
        end else if (cyc_cnt_q == 32'(ECHO_TIMEOUT - 1)) begin
          state_d   = HOLDOFF;
          cyc_cnt_d = 32'd0;
          dist_d    = 16'd0;
          valid_d   = 1'b1;
          tmo_d     = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
      end
      MEASURE: begin
        // Each MEASURE cycle stands for one high cycle one step earlier, so the fall cycle closes the count
        echo_cnt_d = echo_cnt_q + 16'd1;
        if (echo_cnt_d == 16'(ECHO_TIMEOUT)) begin
          state_d   = HOLDOFF;
          cyc_cnt_d = 32'd0;
          dist_d    = 16'd0;
          valid_d   = 1'b1;
          tmo_d     = 1'b1;
        end else if (echo_fall) begin
          state_d   = HOLDOFF;
          cyc_cnt_d = 32'd0;
          dist_d    = echo_cnt_d >> DIST_SHIFT;
          valid_d   = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cyc_cnt_q == 32'(HOLDOFF_CYCLES - 1)) begin
          state_d   = IDLE;
          cyc_cnt_d = 32'd0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Alarm follows the counter update in the same cycle so it shows the cycle after the deciding strobe
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    alarm_d    = alarm_q;
    if (valid_q) begin
      if (is_hit) begin
        miss_cnt_d = '0;
        if (hit_cnt_q != HW'(HIT_COUNT)) hit_cnt_d = hit_cnt_q + HW'(1);
        if (hit_cnt_d == HW'(HIT_COUNT)) alarm_d = 1'b1;
      end else begin
        hit_cnt_d = '0;
        if (miss_cnt_q != HW'(HIT_COUNT)) miss_cnt_d = miss_cnt_q + HW'(1);
        if (miss_cnt_d == HW'(HIT_COUNT)) alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= 32'd0;
      echo_cnt_q  <= 16'd0;
      dist_q      <= 16'd0;
      valid_q     <= 1'b0;
      tmo_q       <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      alarm_q     <= 1'b0;
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      echo_cnt_q  <= echo_cnt_d;
      dist_q      <= dist_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      alarm_q     <= alarm_d;
      echo_s1_q   <= echo_in;
      echo_s2_q   <= echo_s1_q;
      echo_prev_q <= echo_s2_q;
    end
  end

  assign trig_out       = (state_q == TRIG);
  assign busy           = (state_q != IDLE);
  assign distance_value = dist_q;
  assign distance_valid = valid_q;
  assign timeout        = tmo_q;
  assign alarm_active   = alarm_q;

endmodule

// File: tb/tb_ping_scheduler.sv
// tb/tb_ping_scheduler.sv - directed self-checking bench for ping_scheduler
module tb_ping_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        echo_in;
  logic        trig_out;
  logic        busy;
  logic [15:0] distance_value;
  logic        distance_valid;
  logic        timeout;
  logic        alarm_active;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nstrobe = 0, ntrig = 0, nfall = 0;
  int last_dist = 0, last_tmo = 0, strobe_cyc = 0;
  int trig_rise_cyc = 0, trig_fall_cyc = 0, trig_len = 0, last_trig_len = 0;
  logic trig_prev = 1'b0;

  ping_scheduler #(
    .TRIG_CYCLES(4), .ECHO_TIMEOUT(4000), .HOLDOFF_CYCLES(20),
    .DIST_SHIFT(2), .THRESHOLD(200), .HIT_COUNT(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo_in(echo_in),
    .trig_out(trig_out), .busy(busy), .distance_value(distance_value),
    .distance_valid(distance_valid), .timeout(timeout), .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (distance_valid) begin
      nstrobe++;
      last_dist  = int'(distance_value);
      last_tmo   = int'(timeout);
      strobe_cyc = cyc;
    end
    if (trig_out && !trig_prev) begin
      ntrig++;
      trig_rise_cyc = cyc;
      trig_len = 0;
    end
    if (trig_out) trig_len++;
    if (!trig_out && trig_prev) begin
      nfall++;
      trig_fall_cyc = cyc;
      last_trig_len = trig_len;
    end
    trig_prev = trig_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fall();
    int f0 = nfall;
    int k = 0;
    while (nfall == f0 && k < 200) begin step(); k++; end
    if (nfall == f0) check("trig_fall_wait", 0, 1);
  endtask

  task automatic wait_strobe(input int n0);
    int k = 0;
    while (nstrobe == n0 && k < 6000) begin step(); k++; end
    if (nstrobe == n0) check("strobe_wait", 0, 1);
  endtask

  task automatic wait_trig_rise();
    int t0 = ntrig;
    int k = 0;
    while (ntrig == t0 && k < 200) begin step(); k++; end
    if (ntrig == t0) check("trig_rise_wait", 0, 1);
  endtask

  // width==0 leaves echo_in untouched
  task automatic meas(input int rise_delay, input int width);
    int n0 = nstrobe;
    wait_fall();
    if (width > 0) begin
      repeat (rise_delay) step();
      echo_in = 1'b1;
      repeat (width) step();
      echo_in = 1'b0;
    end
    wait_strobe(n0);
  endtask

  initial begin
    int n0, t0;
    rst = 1'b1; enable = 1'b0; echo_in = 1'b0;
    repeat (3) step();
    check("rst_trig", trig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_dist", distance_value, 0);
    check("rst_valid", distance_valid, 0);
    check("rst_tmo", timeout, 0);
    check("rst_alarm", alarm_active, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // 1: basic measurement and re-trigger spacing
    enable = 1'b1;
    meas(50, 600);
    check("s1_trig_len", last_trig_len, 4);
    check("s1_dist", last_dist, 150);
    check("s1_tmo", last_tmo, 0);
    step();
    check("s1_valid_one", distance_valid, 0);
    wait_trig_rise();
    check("s1_retrig", trig_rise_cyc - strobe_cyc, 21);

    // 2: far objects never alarm
    for (int i = 0; i < 3; i++) begin
      meas(10, 2000);
      check("s2_dist", last_dist, 500);
      check("s2_tmo", last_tmo, 0);
      step();
      check("s2_alarm", alarm_active, 0);
    end

    // 3: distance at threshold is a miss, two hits raise alarm
    for (int i = 0; i < 2; i++) begin
      meas(10, 800);
      check("s3_dist200", last_dist, 200);
      step();
      check("s3_alarm_200", alarm_active, 0);
    end
    meas(10, 600);
    check("s3_dist150a", last_dist, 150);
    step();
    check("s3_alarm_hit1", alarm_active, 0);
    meas(10, 600);
    check("s3_dist150b", last_dist, 150);
    check("s3_alarm_strobe", alarm_active, 0);
    step();
    check("s3_alarm_set", alarm_active, 1);

    // 4: no echo, timeouts clear alarm
    meas(0, 0);
    check("s4_dist_a", last_dist, 0);
    check("s4_tmo_a", last_tmo, 1);
    check("s4_wait_len", strobe_cyc - trig_fall_cyc, 4000);
    step();
    check("s4_alarm_kept", alarm_active, 1);
    meas(0, 0);
    check("s4_tmo_b", last_tmo, 1);
    check("s4_alarm_strobe", alarm_active, 1);
    step();
    check("s4_alarm_clr", alarm_active, 0);

    // 5: echo already high gives timeout, then close hits
    echo_in = 1'b1;
    meas(0, 0);
    check("s5_dist_hi", last_dist, 0);
    check("s5_tmo_hi", last_tmo, 1);
    echo_in = 1'b0;
    meas(10, 40);
    check("s5_dist10a", last_dist, 10);
    meas(10, 40);
    check("s5_dist10b", last_dist, 10);
    step();
    check("s5_alarm", alarm_active, 1);

    // 6a: reset in MEASURE
    n0 = nstrobe;
    wait_fall();
    repeat (10) step();
    echo_in = 1'b1;
    repeat (100) step();
    rst = 1'b1;
    #1;
    check("s6_rst_trig", trig_out, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_dist", distance_value, 0);
    check("s6_rst_valid", distance_valid, 0);
    check("s6_rst_tmo", timeout, 0);
    check("s6_rst_alarm", alarm_active, 0);
    echo_in = 1'b0;
    repeat (5) step();
    check("s6_rst_nostrobe", nstrobe, n0);
    rst = 1'b0;
    step();

    // 6b: enable drop in MEASURE finishes the measurement then parks
    n0 = nstrobe;
    wait_fall();
    repeat (10) step();
    echo_in = 1'b1;
    repeat (100) step();
    enable = 1'b0;
    repeat (200) step();
    echo_in = 1'b0;
    wait_strobe(n0);
    check("s6_en_dist", last_dist, 75);
    check("s6_en_tmo", last_tmo, 0);
    repeat (19) step();
    check("s6_busy_hold", busy, 1);
    step();
    check("s6_busy_low", busy, 0);
    t0 = ntrig;
    repeat (60) step();
    check("s6_no_trig", ntrig, t0);
    check("s6_one_strobe", nstrobe, n0 + 1);
    check("s6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
